// File: rtl/gst_mp.sv
// gst_mp -- multi-port global state table.
//
// Holds the assignment of every SAT variable (2 bits each: 00 UNDEF,
// 01 TRUE, 10 FALSE) and answers clause lookups from NUM_ENGINE BCP
// engines in parallel with one cycle of latency. Unit clauses from the
// UC arbiter FIFO are drained only while every engine is idle. Conflicting
// unit assignments raise a sticky conflict flag.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   rd_req         per-engine lookup request
//   rd_cla         per-engine clause; literal k of engine e sits at
//                  bits [(e*CLA_LENGTH+k)*LIT_W +: LIT_W]
//   rd_state       per-literal state, same ordering, 2 bits per literal
//   rd_valid       rd_state valid, one cycle after rd_req
//   eng_idle       engine finished BCP for this round
//   update_finish  one-cycle pulse on every engine after a table update
//   uc_lit/uc_empty/uc_pop  first-word fall-through UC FIFO interface
//   conflict, conflict_var, conflict_clr  sticky conflict report
//   assign_cnt     number of assigned variables
//
// Optional build macro GST_MP_TRAIL_EN adds a trail of assignments and the
// bt_req/bt_num ports; a backtrack request undoes the most recent
// min(bt_num, assign_cnt) assignments, one per cycle.
module gst_mp #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_LENGTH = 3,
  parameter int NUM_VAR    = 64,
  parameter int LIT_W      = $clog2(NUM_VAR) + 1,
  localparam int VAR_W     = LIT_W - 1,
  localparam int CNT_W     = $clog2(NUM_VAR) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_ENGINE-1:0]                rd_req,
  input  logic [NUM_ENGINE*CLA_LENGTH*LIT_W-1:0] rd_cla,
  output logic [NUM_ENGINE*CLA_LENGTH*2-1:0]   rd_state,
  output logic [NUM_ENGINE-1:0]                rd_valid,
  input  logic [NUM_ENGINE-1:0]                eng_idle,
  output logic [NUM_ENGINE-1:0]                update_finish,
  input  logic [LIT_W-1:0]                     uc_lit,
  input  logic                                 uc_empty,
  output logic                                 uc_pop,
  output logic                                 conflict,
  output logic [VAR_W-1:0]                     conflict_var,
  input  logic                                 conflict_clr,
  output logic [CNT_W-1:0]                     assign_cnt
`ifdef GST_MP_TRAIL_EN
  ,
  input  logic                                 bt_req,
  input  logic [CNT_W-1:0]                     bt_num
`endif
);

  localparam logic [2:0] S_READ    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_FINISH  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
`ifdef GST_MP_TRAIL_EN
  localparam logic [2:0] S_UNDO    = 3'd4;
`endif

  localparam logic [1:0] ST_UNDEF = 2'b00;
  localparam logic [1:0] ST_TRUE  = 2'b01;
  localparam logic [1:0] ST_FALSE = 2'b10;

  localparam logic [LIT_W-1:0] LIT_MIN = {1'b1, {VAR_W{1'b0}}};

  // Magnitude of a literal, truncated to the variable index width.
  function automatic logic [VAR_W-1:0] lit_abs(input logic signed [LIT_W-1:0] lit);
    logic signed [LIT_W-1:0] neg;
    neg = -lit;
    return lit[LIT_W-1] ? neg[VAR_W-1:0] : lit[VAR_W-1:0];
  endfunction

  // State seen through a literal: null reads FALSE, negation swaps TRUE/FALSE.
  function automatic logic [1:0] lit_state(input logic signed [LIT_W-1:0] lit,
                                           input logic [1:0] var_st);
    if (lit == '0) return ST_FALSE;
    if (lit[LIT_W-1] && var_st != ST_UNDEF) return {var_st[0], var_st[1]};
    return var_st;
  endfunction

  logic [2:0]                        state_q, state_d;
  logic [1:0]                        table_q [NUM_VAR];
  logic [1:0]                        table_d [NUM_VAR];
  logic [NUM_ENGINE-1:0]             rd_valid_q, rd_valid_d;
  logic [NUM_ENGINE*CLA_LENGTH*2-1:0] rd_state_q, rd_state_d;
  logic                              conflict_q, conflict_d;
  logic [VAR_W-1:0]                  conflict_var_q, conflict_var_d;
  logic [CNT_W-1:0]                  assign_cnt_q, assign_cnt_d;
  logic signed [LIT_W-1:0]           rd_lit;
  logic signed [LIT_W-1:0]           wr_lit;
  logic [VAR_W-1:0]                  wr_var;
  logic [1:0]                        wr_val;
`ifdef GST_MP_TRAIL_EN
  logic [VAR_W-1:0]                  trail_q [NUM_VAR];
  logic [VAR_W-1:0]                  trail_d [NUM_VAR];
  logic [CNT_W-1:0]                  undo_rem_q, undo_rem_d;
  logic [CNT_W-1:0]                  bt_len;
  logic [CNT_W-1:0]                  top_idx;
`endif

  always_comb begin
    state_d        = state_q;
    table_d        = table_q;
    rd_valid_d     = '0;
    rd_state_d     = '0;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    assign_cnt_d   = assign_cnt_q;
    uc_pop         = 1'b0;
    rd_lit         = '0;
    wr_lit         = uc_lit;
    wr_var         = lit_abs(wr_lit);
    wr_val         = wr_lit[LIT_W-1] ? ST_FALSE : ST_TRUE;
`ifdef GST_MP_TRAIL_EN
    trail_d        = trail_q;
    undo_rem_d     = undo_rem_q;
    bt_len         = (bt_num < assign_cnt_q) ? bt_num : assign_cnt_q;
    top_idx        = assign_cnt_q - CNT_W'(1);
`endif

    // A conflict detected below in the same cycle overrides the clear.
    if (conflict_clr) begin
      conflict_d     = 1'b0;
      conflict_var_d = '0;
    end

    case (state_q)
      S_READ: begin
        rd_valid_d = rd_req;
        for (int e = 0; e < NUM_ENGINE; e++) begin
          for (int k = 0; k < CLA_LENGTH; k++) begin
            rd_lit = rd_cla[(e*CLA_LENGTH+k)*LIT_W +: LIT_W];
            if (rd_req[e])
              rd_state_d[(e*CLA_LENGTH+k)*2 +: 2] = lit_state(rd_lit, table_q[lit_abs(rd_lit)]);
          end
        end
`ifdef GST_MP_TRAIL_EN
        if (bt_req && bt_len != '0) begin
          state_d    = S_UNDO;
          undo_rem_d = bt_len;
        end else
`endif
        if (&eng_idle) state_d = uc_empty ? S_FINISH : S_WRITE;
      end

      S_WRITE: begin
        if (uc_empty) begin
          state_d = S_FINISH;
        end else begin
          // Gated by reset so a reset mid-drain leaves the FIFO untouched.
          uc_pop = rst_n;
          if (wr_lit != '0) begin
            if (table_q[wr_var] == ST_UNDEF) begin
              table_d[wr_var] = wr_val;
              assign_cnt_d    = assign_cnt_q + CNT_W'(1);
`ifdef GST_MP_TRAIL_EN
              trail_d[assign_cnt_q[VAR_W-1:0]] = wr_var;
`endif
            end else if (table_q[wr_var] != wr_val) begin
              conflict_d = 1'b1;
              if (!conflict_q || conflict_clr) conflict_var_d = wr_var;
            end
          end
        end
      end

      S_FINISH: state_d = S_RELEASE;

      // Hold until engines drop idle so one round yields one finish pulse.
      S_RELEASE: if (eng_idle == '0) state_d = S_READ;

`ifdef GST_MP_TRAIL_EN
      S_UNDO: begin
        if (undo_rem_q != '0) begin
          table_d[trail_q[top_idx[VAR_W-1:0]]] = ST_UNDEF;
          assign_cnt_d = assign_cnt_q - CNT_W'(1);
          undo_rem_d   = undo_rem_q - CNT_W'(1);
        end
        if (undo_rem_q <= CNT_W'(1)) state_d = S_READ;
      end
`endif

      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_READ;
      rd_valid_q     <= '0;
      rd_state_q     <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      assign_cnt_q   <= '0;
      for (int i = 0; i < NUM_VAR; i++) table_q[i] <= ST_UNDEF;
`ifdef GST_MP_TRAIL_EN
      undo_rem_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rd_valid_q     <= rd_valid_d;
      rd_state_q     <= rd_state_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      assign_cnt_q   <= assign_cnt_d;
      table_q        <= table_d;
`ifdef GST_MP_TRAIL_EN
      undo_rem_q     <= undo_rem_d;
`endif
    end
  end

`ifdef GST_MP_TRAIL_EN
  // Trail contents are only meaningful below assign_cnt; no reset needed.
  always_ff @(posedge clk) trail_q <= trail_d;
`endif

  assign rd_state      = rd_state_q;
  assign rd_valid      = rd_valid_q;
  assign update_finish = {NUM_ENGINE{state_q == S_FINISH}};
  assign conflict      = conflict_q;
  assign conflict_var  = conflict_var_q;
  assign assign_cnt    = assign_cnt_q;

  // The most negative literal has no representable magnitude.
  a_uc_lit_legal: assert property (@(posedge clk) disable iff (!rst_n)
    uc_pop |-> uc_lit != LIT_MIN);

endmodule

// File: tb/tb_gst_mp.sv
`timescale 1ns/1ps
module tb_gst_mp;
  localparam int NE = 4;
  localparam int CL = 3;
  localparam int NV = 64;
  localparam int LW = 7;
  localparam int VW = 6;
  localparam int CW = 7;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NE-1:0]       rd_req = '0;
  logic [NE*CL*LW-1:0] rd_cla = '0;
  logic [NE*CL*2-1:0]  rd_state;
  logic [NE-1:0]       rd_valid;
  logic [NE-1:0]       eng_idle = '0;
  logic [NE-1:0]       update_finish;
  logic [LW-1:0]       uc_lit = '0;
  logic                uc_empty = 1'b1;
  logic                uc_pop;
  logic                conflict;
  logic [VW-1:0]       conflict_var;
  logic                conflict_clr = 1'b0;
  logic [CW-1:0]       assign_cnt;
`ifdef GST_MP_TRAIL_EN
  logic                bt_req = 1'b0;
  logic [CW-1:0]       bt_num = '0;
`endif

  int errors = 0;
  int checks = 0;

  gst_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_cla(rd_cla),
    .rd_state(rd_state), .rd_valid(rd_valid), .eng_idle(eng_idle),
    .update_finish(update_finish), .uc_lit(uc_lit), .uc_empty(uc_empty),
    .uc_pop(uc_pop), .conflict(conflict), .conflict_var(conflict_var),
    .conflict_clr(conflict_clr), .assign_cnt(assign_cnt)
`ifdef GST_MP_TRAIL_EN
    , .bt_req(bt_req), .bt_num(bt_num)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: variable values, assignment order, conflict report.
  logic [1:0] mtab [NV];
  int         mcnt;
  bit         mconf;
  int         mcvar;
  int         mtrail[$];
  int         fifo[$];
  int         cla[NE*CL];
  int         popped_lit;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int rand_lit();
    return int'($urandom_range(126)) - 63;
  endfunction

  function automatic logic [1:0] m_look(input int lit);
    logic [1:0] s;
    if (lit == 0) return 2'b10;
    s = mtab[iabs(lit)];
    if (lit < 0 && s != 2'b00) return 2'b11 - s;
    return s;
  endfunction

  task automatic model_apply(input int lit);
    int v;
    logic [1:0] val;
    if (lit == 0) return;
    v   = iabs(lit);
    val = (lit > 0) ? 2'b01 : 2'b10;
    if (mtab[v] == 2'b00) begin
      mtab[v] = val;
      mcnt++;
      mtrail.push_back(v);
    end else if (mtab[v] != val) begin
      if (!mconf) mcvar = v;
      mconf = 1'b1;
    end
  endtask

  task automatic fifo_sync();
    uc_empty = (fifo.size() == 0);
    uc_lit   = uc_empty ? '0 : LW'(fifo[0]);
  endtask

  // FIFO behaviour: a pop requested in a cycle consumes the head at the edge.
  always @(negedge clk) begin
    if (uc_pop === 1'b1) begin
      @(posedge clk);
      #1;
      if (fifo.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL pop_on_empty: uc_pop=1 with FIFO empty");
      end else begin
        popped_lit = fifo.pop_front();
        model_apply(popped_lit);
      end
      fifo_sync();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_req = '0;
    eng_idle = '0;
    conflict_clr = 1'b0;
`ifdef GST_MP_TRAIL_EN
    bt_req = 1'b0;
`endif
    fifo.delete();
    fifo_sync();
    for (int i = 0; i < NV; i++) mtab[i] = 2'b00;
    mcnt = 0;
    mconf = 1'b0;
    mcvar = 0;
    mtrail.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one lookup with the literals in cla[] and compare against the model.
  task automatic do_lookup(input logic [NE-1:0] mask, input string tag);
    logic [1:0] got, exp;
    for (int i = 0; i < NE*CL; i++) rd_cla[i*LW +: LW] = LW'(cla[i]);
    rd_req = mask;
    tick();
    rd_req = '0;
    checks++;
    if (rd_valid !== mask) begin
      errors++;
      $display("FAIL %s rd_valid: got %b want %b", tag, rd_valid, mask);
    end
    for (int e = 0; e < NE; e++) begin
      if (mask[e]) begin
        for (int k = 0; k < CL; k++) begin
          got = rd_state[(e*CL+k)*2 +: 2];
          exp = m_look(cla[e*CL+k]);
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL %s e%0d k%0d lit %0d: got %b want %b", tag, e, k, cla[e*CL+k], got, exp);
          end
        end
      end
    end
    checks++;
    if (assign_cnt !== CW'(mcnt) || conflict !== mconf || conflict_var !== VW'(mcvar)) begin
      errors++;
      $display("FAIL %s status: cnt %0d conf %b var %0d want cnt %0d conf %b var %0d",
               tag, assign_cnt, conflict, conflict_var, mcnt, mconf, mcvar);
    end
  endtask

  // Drain whatever is queued in fifo with all engines idle, then release.
  task automatic do_drain(input bit hold_rd, input string tag);
    int n, first_pop, last_pop, npop, nfin, fin_idx, window, exp_fin;
    logic [NE-1:0] exp_v;
    n = fifo.size();
    fifo_sync();
    first_pop = -1; last_pop = -1; npop = 0; nfin = 0; fin_idx = -1;
    window = n + 12;
    eng_idle = '1;
    if (hold_rd) rd_req = '1;
    for (int i = 1; i <= window; i++) begin
      tick();
      if (uc_pop === 1'b1) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        npop++;
      end
      if (update_finish !== '0) begin
        nfin++;
        if (fin_idx < 0) fin_idx = i;
        checks++;
        if (update_finish !== '1) begin
          errors++;
          $display("FAIL %s finish_width: got %b want %b", tag, update_finish, {NE{1'b1}});
        end
      end
      if (hold_rd) begin
        exp_v = (i == 1) ? '1 : '0;
        checks++;
        if (rd_valid !== exp_v) begin
          errors++;
          $display("FAIL %s rd_valid_busy cyc %0d: got %b want %b", tag, i, rd_valid, exp_v);
        end
      end
    end
    rd_req = '0;
    eng_idle = '0;
    exp_fin = (n > 0) ? n + 2 : 1;
    checks++;
    if (npop != n || (n > 0 && (first_pop != 1 || last_pop != n))) begin
      errors++;
      $display("FAIL %s pops: got %0d (cyc %0d..%0d) want %0d (cyc 1..%0d)", tag, npop, first_pop, last_pop, n, n);
    end
    checks++;
    if (nfin != 1 || fin_idx != exp_fin) begin
      errors++;
      $display("FAIL %s finish: got %0d pulses first cyc %0d want 1 pulse cyc %0d", tag, nfin, fin_idx, exp_fin);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_valid !== '0 || rd_state !== '0) begin
      errors++;
      $display("FAIL reset_rd: rd_valid %b rd_state %h want 0", rd_valid, rd_state);
    end
    checks++;
    if (update_finish !== '0 || uc_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: update_finish %b uc_pop %b want 0", update_finish, uc_pop);
    end
    checks++;
    if (conflict !== 1'b0 || conflict_var !== '0 || assign_cnt !== '0) begin
      errors++;
      $display("FAIL reset_status: conflict %b var %0d cnt %0d want 0", conflict, conflict_var, assign_cnt);
    end
  endtask

  task automatic test_lookup_basic();
    for (int i = 0; i < NE*CL; i++) cla[i] = 0;
    cla[0] = 3; cla[1] = -5; cla[2] = 0;
    do_lookup(4'b0001, "lookup_basic");
    checks++;
    if (rd_state[5:0] !== 6'b10_00_00 || assign_cnt !== '0) begin
      errors++;
      $display("FAIL lookup_basic_const: got %b cnt %0d want 100000 cnt 0", rd_state[5:0], assign_cnt);
    end
  endtask

  task automatic test_drain();
    fifo.push_back(5);
    fifo.push_back(-7);
    do_drain(1'b0, "drain");
    cla[0] = -5; cla[1] = 7; cla[2] = 5;
    do_lookup(4'b0001, "drain_lookup");
    checks++;
    if (rd_state[5:0] !== 6'b01_10_10 || assign_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL drain_const: got %b cnt %0d want 011010 cnt 2", rd_state[5:0], assign_cnt);
    end
  endtask

  task automatic test_conflict();
    fifo.push_back(-5);
    fifo.push_back(9);
    do_drain(1'b1, "conflict_drain");
    checks++;
    if (conflict !== 1'b1 || conflict_var !== VW'(5)) begin
      errors++;
      $display("FAIL conflict_flag: got %b var %0d want 1 var 5", conflict, conflict_var);
    end
    cla[0] = 5; cla[1] = 9; cla[2] = -5;
    do_lookup(4'b0001, "conflict_lookup");
    checks++;
    if (rd_state[5:0] !== 6'b10_01_01) begin
      errors++;
      $display("FAIL conflict_table: got %b want 100101", rd_state[5:0]);
    end
    fifo.push_back(-9);
    do_drain(1'b0, "second_conflict");
    checks++;
    if (conflict !== 1'b1 || conflict_var !== VW'(5)) begin
      errors++;
      $display("FAIL first_conflict_kept: got %b var %0d want 1 var 5", conflict, conflict_var);
    end
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    mconf = 1'b0;
    mcvar = 0;
    checks++;
    if (conflict !== 1'b0 || conflict_var !== '0) begin
      errors++;
      $display("FAIL conflict_clr: got %b var %0d want 0 var 0", conflict, conflict_var);
    end
  endtask

  task automatic test_empty_finish();
    do_drain(1'b0, "empty_finish");
  endtask

  task automatic test_multi_engine();
    int fixed [NE*CL] = '{5, -5, 0, 7, -7, 3, 9, -9, 1, -1, 63, -63};
    for (int i = 0; i < NE*CL; i++) cla[i] = fixed[i];
    do_lookup('1, "multi_fixed");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NE*CL; i++) cla[i] = rand_lit();
      do_lookup((r == 0) ? '1 : NE'($urandom_range(1, 15)), "multi_rand");
    end
  endtask

  task automatic test_random_rounds();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(6));
      for (int i = 0; i < n; i++) fifo.push_back(rand_lit());
      do_drain(bit'($urandom_range(1)), "rand_drain");
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < NE*CL; i++) cla[i] = rand_lit();
        do_lookup(NE'($urandom_range(1, 15)), "rand_lookup");
      end
      if ($urandom_range(1) == 1) begin
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        mconf = 1'b0;
        mcvar = 0;
      end
    end
  endtask

`ifdef GST_MP_TRAIL_EN
  task automatic test_backtrack();
    do_reset();
    fifo.push_back(5);
    fifo.push_back(-7);
    fifo.push_back(9);
    do_drain(1'b0, "bt_fill");
    bt_num = CW'(2);
    bt_req = 1'b1;
    rd_req = '1;
    tick();
    bt_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== '0) begin
      errors++;
      $display("FAIL bt_rd_valid_undo1: got %b want 0000", rd_valid);
    end
    tick();
    rd_req = '0;
    checks++;
    if (rd_valid !== '0 || assign_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL bt_undo2: rd_valid %b cnt %0d want 0000 cnt 1", rd_valid, assign_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      mtab[mtrail.pop_back()] = 2'b00;
      mcnt--;
    end
    tick();
    for (int i = 0; i < NE*CL; i++) cla[i] = 0;
    cla[0] = 5; cla[1] = 7; cla[2] = 9;
    do_lookup(4'b0001, "bt_lookup");
    checks++;
    if (rd_state[5:0] !== 6'b00_00_01) begin
      errors++;
      $display("FAIL bt_table: got %b want 000001", rd_state[5:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lookup_basic();
    test_drain();
    test_conflict();
    test_empty_finish();
    test_multi_engine();
    test_random_rounds();
`ifdef GST_MP_TRAIL_EN
    test_backtrack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
